// File: rtl/tank_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tank_pkg : directions, screen sizes and bullet states shared by tank logic
// Rev 1.0
// ----------------------------------------------------------------------------
package tank_pkg;

  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;

  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;

  // Off-screen coordinate that keeps the renderer's comparators false.
  localparam logic [9:0] PARK_POS = 10'd1023;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SPAWN    = 2'd1,
    FLY      = 2'd2,
    COOLDOWN = 2'd3
  } bullet_state_t;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v == DIR_UP) || (v == DIR_DOWN) || (v == DIR_LEFT) || (v == DIR_RIGHT);
  endfunction

endpackage : tank_pkg
`default_nettype wire

// File: rtl/bullet_bounds_check.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bullet_bounds_check : combinational test that a signed bullet corner is on screen
// Rev 1.0
// ----------------------------------------------------------------------------
module bullet_bounds_check #(
  parameter int MAX_X = 632,
  parameter int MAX_Y = 472
) (
  input  logic signed [10:0] x_i,
  input  logic signed [10:0] y_i,
  output logic               in_bounds_o
);

  localparam logic signed [10:0] c_MAX_X = 11'(MAX_X);
  localparam logic signed [10:0] c_MAX_Y = 11'(MAX_Y);

  assign in_bounds_o = !x_i[10] && !y_i[10] && (x_i <= c_MAX_X) && (y_i <= c_MAX_Y);

endmodule : bullet_bounds_check
`default_nettype wire

// File: rtl/bullet_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bullet_controller : spawn, per-frame motion, retirement and cooldown of one bullet
// Rev 1.0
// ----------------------------------------------------------------------------
module bullet_controller
  import tank_pkg::*;
#(
  parameter int SCREEN_W        = DEF_SCREEN_W,
  parameter int SCREEN_H        = DEF_SCREEN_H,
  parameter int TANK_SIZE       = 32,
  parameter int BULLET_SIZE     = 8,
  parameter int SPEED           = 4,
  parameter int COOLDOWN_FRAMES = 15
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       fire,
  input  logic [9:0] tankx,
  input  logic [9:0] tanky,
  input  logic [3:0] TankDir,
  input  logic       hit,
  output logic [9:0] bullet_x,
  output logic [9:0] bullet_y,
  output logic [3:0] bullet_dir,
  output logic       bullet_active,
  output logic       fire_ready
);

  localparam int CD_W = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

  localparam logic signed [10:0] c_CENTER = 11'((TANK_SIZE - BULLET_SIZE) / 2);
  localparam logic signed [10:0] c_TANK   = 11'(TANK_SIZE);
  localparam logic signed [10:0] c_BULLET = 11'(BULLET_SIZE);
  localparam logic signed [10:0] c_SPEED  = 11'(SPEED);
  localparam logic [CD_W-1:0]    c_CD     = CD_W'(COOLDOWN_FRAMES);
  localparam bullet_state_t      c_RETIRE = (COOLDOWN_FRAMES == 0) ? IDLE : COOLDOWN;

  bullet_state_t   state_q, state_d;
  logic            fire_q;
  logic            hold_q;
  logic [3:0]      dir_q, dir_d;
  logic [9:0]      x_q, x_d;
  logic [9:0]      y_q, y_d;
  logic            active_q, active_d;
  logic            ready_q, ready_d;
  logic [CD_W-1:0] cd_q, cd_d;

  logic signed [10:0] tank_x_s, tank_y_s, cur_x_s, cur_y_s;
  logic signed [10:0] spawn_x, spawn_y, step_x, step_y;
  logic               spawn_ok, step_ok, fire_edge, retire;

  // hold_q masks a button that was already down when reset released.
  assign fire_edge = fire & ~fire_q & ~hold_q;

  assign tank_x_s = signed'({1'b0, tankx});
  assign tank_y_s = signed'({1'b0, tanky});
  assign cur_x_s  = signed'({1'b0, x_q});
  assign cur_y_s  = signed'({1'b0, y_q});

  always_comb begin
    spawn_x = tank_x_s + c_CENTER;
    spawn_y = tank_y_s + c_CENTER;
    step_x  = cur_x_s;
    step_y  = cur_y_s;
    case (dir_q)
      DIR_UP: begin
        spawn_y = tank_y_s - c_BULLET;
        step_y  = cur_y_s - c_SPEED;
      end
      DIR_DOWN: begin
        spawn_y = tank_y_s + c_TANK;
        step_y  = cur_y_s + c_SPEED;
      end
      DIR_LEFT: begin
        spawn_x = tank_x_s - c_BULLET;
        step_x  = cur_x_s - c_SPEED;
      end
      DIR_RIGHT: begin
        spawn_x = tank_x_s + c_TANK;
        step_x  = cur_x_s + c_SPEED;
      end
      default: ;
    endcase
  end

  bullet_bounds_check #(
    .MAX_X(SCREEN_W - BULLET_SIZE),
    .MAX_Y(SCREEN_H - BULLET_SIZE)
  ) u_spawn_bounds (
    .x_i        (spawn_x),
    .y_i        (spawn_y),
    .in_bounds_o(spawn_ok)
  );

  bullet_bounds_check #(
    .MAX_X(SCREEN_W - BULLET_SIZE),
    .MAX_Y(SCREEN_H - BULLET_SIZE)
  ) u_step_bounds (
    .x_i        (step_x),
    .y_i        (step_y),
    .in_bounds_o(step_ok)
  );

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    x_d      = x_q;
    y_d      = y_q;
    active_d = active_q;
    cd_d     = cd_q;
    retire   = 1'b0;

    case (state_q)
      IDLE: begin
        if (fire_edge && is_onehot4(TankDir)) begin
          state_d = SPAWN;
          dir_d   = TankDir;
        end
      end
      SPAWN: begin
        if (spawn_ok) begin
          state_d  = FLY;
          x_d      = spawn_x[9:0];
          y_d      = spawn_y[9:0];
          active_d = 1'b1;
        end else begin
          retire = 1'b1;
        end
      end
      FLY: begin
        if (hit) begin
          retire = 1'b1;
        end else if (frame_tick) begin
          if (step_ok) begin
            x_d = step_x[9:0];
            y_d = step_y[9:0];
          end else begin
            retire = 1'b1;
          end
        end
      end
      COOLDOWN: begin
        if (frame_tick) begin
          if (cd_q <= CD_W'(1)) begin
            state_d = IDLE;
            cd_d    = '0;
          end else begin
            cd_d = cd_q - CD_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (retire) begin
      state_d  = c_RETIRE;
      cd_d     = c_CD;
      x_d      = PARK_POS;
      y_d      = PARK_POS;
      active_d = 1'b0;
    end

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      fire_q   <= 1'b0;
      hold_q   <= fire;
      dir_q    <= 4'd0;
      x_q      <= PARK_POS;
      y_q      <= PARK_POS;
      active_q <= 1'b0;
      ready_q  <= 1'b1;
      cd_q     <= '0;
    end else begin
      state_q  <= state_d;
      fire_q   <= fire;
      hold_q   <= hold_q & fire;
      dir_q    <= dir_d;
      x_q      <= x_d;
      y_q      <= y_d;
      active_q <= active_d;
      ready_q  <= ready_d;
      cd_q     <= cd_d;
    end
  end

  assign bullet_x      = x_q;
  assign bullet_y      = y_q;
  assign bullet_dir    = dir_q;
  assign bullet_active = active_q;
  assign fire_ready    = ready_q;

endmodule : bullet_controller
`default_nettype wire

// File: tb/tb_bullet_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_bullet_controller : directed bench for bullet_controller (default parameters)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_bullet_controller;

  logic       vga_clk = 1'b0;
  logic       reset_n;
  logic       frame_tick;
  logic       fire;
  logic [9:0] tankx;
  logic [9:0] tanky;
  logic [3:0] TankDir;
  logic       hit;
  logic [9:0] bullet_x;
  logic [9:0] bullet_y;
  logic [3:0] bullet_dir;
  logic       bullet_active;
  logic       fire_ready;

  int checks = 0;
  int errors = 0;

  bullet_controller dut (
    .vga_clk      (vga_clk),
    .reset_n      (reset_n),
    .frame_tick   (frame_tick),
    .fire         (fire),
    .tankx        (tankx),
    .tanky        (tanky),
    .TankDir      (TankDir),
    .hit          (hit),
    .bullet_x     (bullet_x),
    .bullet_y     (bullet_y),
    .bullet_dir   (bullet_dir),
    .bullet_active(bullet_active),
    .fire_ready   (fire_ready)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic chk(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic chk_parked(input string tag);
    chk({tag, "_active"}, int'(bullet_active), 0);
    chk({tag, "_x"}, int'(bullet_x), 1023);
    chk({tag, "_y"}, int'(bullet_y), 1023);
  endtask

  initial begin
    reset_n = 1'b0; frame_tick = 1'b0; fire = 1'b0; hit = 1'b0;
    tankx = 10'd100; tanky = 10'd200; TankDir = 4'd8;
    step(); step();
    chk_parked("rst");
    chk("rst_dir", int'(bullet_dir), 0);
    chk("rst_ready", int'(fire_ready), 1);
    reset_n = 1'b1;
    step();
    chk_parked("post_rst");
    chk("post_rst_ready", int'(fire_ready), 1);

    // Right shot from (100,200)
    fire = 1'b1;
    step();
    chk("r_ready_fall", int'(fire_ready), 0);
    chk("r_spawn_inactive", int'(bullet_active), 0);
    fire = 1'b0;
    step();
    chk("r_active", int'(bullet_active), 1);
    chk("r_x", int'(bullet_x), 132);
    chk("r_y", int'(bullet_y), 212);
    chk("r_dir", int'(bullet_dir), 8);
    frame();
    chk("r_x1", int'(bullet_x), 136);
    frames(2);
    chk("r_x3", int'(bullet_x), 144);
    chk("r_y3", int'(bullet_y), 212);
    hit = 1'b1;
    step();
    hit = 1'b0;
    chk_parked("r_hit");
    chk("r_hit_ready", int'(fire_ready), 0);
    frames(14);
    chk("r_cd14_ready", int'(fire_ready), 0);
    frame();
    chk("r_cd15_ready", int'(fire_ready), 1);

    // Up shot at tank y=4 spawns above the screen
    tankx = 10'd300; tanky = 10'd4; TankDir = 4'd1;
    fire = 1'b1;
    step();
    chk("oob_ready_fall", int'(fire_ready), 0);
    fire = 1'b0;
    step();
    chk_parked("oob_spawn");
    chk("oob_ready", int'(fire_ready), 0);
    frames(14);
    chk("oob_cd14_ready", int'(fire_ready), 0);
    frame();
    chk("oob_cd15_ready", int'(fire_ready), 1);

    // Right edge: spawn at x=628
    tankx = 10'd596; tanky = 10'd100; TankDir = 4'd8;
    fire = 1'b1;
    step();
    fire = 1'b0;
    step();
    chk("edge_x0", int'(bullet_x), 628);
    frame();
    chk("edge_x1", int'(bullet_x), 632);
    chk("edge_active1", int'(bullet_active), 1);
    frame();
    chk_parked("edge_exit");
    chk("edge_ready", int'(fire_ready), 0);
    frames(15);
    chk("edge_cd_ready", int'(fire_ready), 1);

    // Down shot, hit and frame_tick together, then fire during cooldown
    tankx = 10'd200; tanky = 10'd100; TankDir = 4'd2;
    fire = 1'b1;
    step();
    fire = 1'b0;
    step();
    chk("dn_y0", int'(bullet_y), 132);
    chk("dn_x0", int'(bullet_x), 212);
    frame();
    chk("dn_y1", int'(bullet_y), 136);
    hit = 1'b1; frame_tick = 1'b1;
    step();
    hit = 1'b0; frame_tick = 1'b0;
    chk_parked("dn_hit");
    fire = 1'b1;
    step();
    fire = 1'b0;
    step();
    frames(15);
    chk("dn_cd_ready", int'(fire_ready), 1);
    step(); step();
    chk("dn_no_queue_ready", int'(fire_ready), 1);
    chk("dn_no_queue_active", int'(bullet_active), 0);

    // Fire held through spawn, flight and cooldown
    tankx = 10'd200; tanky = 10'd200; TankDir = 4'd4;
    fire = 1'b1;
    step(); step();
    chk("hold_active", int'(bullet_active), 1);
    chk("hold_x", int'(bullet_x), 192);
    chk("hold_y", int'(bullet_y), 212);
    frame();
    chk("hold_x1", int'(bullet_x), 188);
    hit = 1'b1;
    step();
    hit = 1'b0;
    frames(15);
    step(); step();
    chk("hold_ready", int'(fire_ready), 1);
    chk("hold_single", int'(bullet_active), 0);
    fire = 1'b0;
    step();
    fire = 1'b1;
    step(); step();
    chk("hold_second", int'(bullet_active), 1);
    chk("hold_second_x", int'(bullet_x), 192);

    // One-cycle reset mid-flight with fire still held
    reset_n = 1'b0;
    step();
    chk_parked("mid_rst");
    chk("mid_rst_dir", int'(bullet_dir), 0);
    chk("mid_rst_ready", int'(fire_ready), 1);
    reset_n = 1'b1;
    step(); step(); step();
    chk("held_thru_rst_active", int'(bullet_active), 0);
    chk("held_thru_rst_ready", int'(fire_ready), 1);
    fire = 1'b0;
    step();

    // Non-one-hot direction is rejected
    TankDir = 4'b0011;
    fire = 1'b1;
    step();
    chk("bad_dir_ready", int'(fire_ready), 1);
    step();
    chk("bad_dir_active", int'(bullet_active), 0);
    fire = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_bullet_controller
`default_nettype wire
